// File: rtl/bus_read_sequencer.sv
// Queues register-read select codes and presents the selected register on the shared bus,
// one result at a time under a valid/ready handshake.
module bus_read_sequencer #(
  parameter int DATA_W = 16,
  parameter int QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd_req,
  input  logic [4:0]                rd_sel,
  output logic                      rd_accept,
  input  logic [14*DATA_W-1:0]      reg_bank,
  output logic [DATA_W-1:0]         bus_out,
  output logic                      bus_valid,
  output logic                      bus_err,
  input  logic                      bus_ready,
  output logic [$clog2(QDEPTH):0]   q_count,
  output logic                      busy
);

  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(QDEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [4:0]        fifo_q [QDEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PW:0]       count_q;
  logic [4:0]        sel_q;
  logic [DATA_W-1:0] bus_out_q;
  logic              bus_valid_q, bus_err_q;
  logic              q_full, q_empty, push, pop;

  function automatic logic sel_ok(input logic [4:0] sel);
    return (sel >= 5'd1) && (sel <= 5'd14);
  endfunction

  function automatic logic [DATA_W-1:0] read_slot(input logic [14*DATA_W-1:0] bank,
                                                   input logic [4:0] sel);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int k = 1; k <= 14; k++)
      if (sel == 5'(k)) r = bank[k*DATA_W-1 -: DATA_W];
    return r;
  endfunction

  // Full is judged on the pre-pop count, so a full queue refuses even when popping.
  assign q_full    = (count_q == FULL_CNT);
  assign q_empty   = (count_q == '0);
  assign push      = rd_req & ~q_full;
  assign pop       = ~q_empty & ((state_q == IDLE) | ((state_q == HOLD) & bus_ready));
  assign rd_accept = push;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!q_empty) state_d = FETCH;
      FETCH:   state_d = HOLD;
      HOLD:    if (bus_ready) state_d = q_empty ? IDLE : FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= rd_sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      sel_q       <= '0;
      bus_out_q   <= '0;
      bus_valid_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        sel_q    <= fifo_q[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // reg_bank is sampled here, at the FETCH edge, not when the request arrived.
      if (state_q == FETCH) begin
        bus_valid_q <= 1'b1;
        bus_err_q   <= ~sel_ok(sel_q);
        bus_out_q   <= sel_ok(sel_q) ? read_slot(reg_bank, sel_q) : '0;
      end else if ((state_q == HOLD) && bus_ready) begin
        bus_valid_q <= 1'b0;
      end
    end
  end

  assign bus_out   = bus_out_q;
  assign bus_valid = bus_valid_q;
  assign bus_err   = bus_err_q;
  assign q_count   = count_q;
  assign busy      = (state_q != IDLE) | ~q_empty;

endmodule

// File: tb/tb_bus_read_sequencer.sv
// Directed and randomized checks of bus_read_sequencer against a queue-based result model.
module tb_bus_read_sequencer;

  localparam int DATA_W = 16;
  localparam int QDEPTH = 4;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    rd_req = 1'b0;
  logic [4:0]              rd_sel = '0;
  logic                    rd_accept;
  logic [14*DATA_W-1:0]    reg_bank = '0;
  logic [DATA_W-1:0]       bus_out;
  logic                    bus_valid;
  logic                    bus_err;
  logic                    bus_ready = 1'b0;
  logic [$clog2(QDEPTH):0] q_count;
  logic                    busy;

  bus_read_sequencer #(.DATA_W(DATA_W), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_sel(rd_sel), .rd_accept(rd_accept),
    .reg_bank(reg_bank), .bus_out(bus_out), .bus_valid(bus_valid), .bus_err(bus_err),
    .bus_ready(bus_ready), .q_count(q_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: pending codes, and the life of the current result
  // (0 = none, 1 = popped and about to be fetched, 2 = on the bus awaiting ready).
  logic [DATA_W-1:0] bank [1:14];
  logic [4:0]        mq [$];
  int                ph = 0;
  logic [4:0]        cur = '0;
  logic              ev = 1'b0, ee = 1'b0;
  logic [DATA_W-1:0] eo = '0;
  logic              last_acc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    ph = 0; cur = '0; ev = 1'b0; ee = 1'b0; eo = '0;
  endtask

  task automatic do_reset();
    rd_req = 1'b0;
    bus_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_clear();
    chk("rst_bus_out", bus_out, 0);
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_q_count", q_count, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cycle(input logic req, input logic [4:0] sel, input logic rdy);
    logic acc;
    rd_req = req;
    rd_sel = sel;
    bus_ready = rdy;
    for (int k = 1; k <= 14; k++) reg_bank[k*DATA_W-1 -: DATA_W] = bank[k];
    #1;
    acc = req && (mq.size() < QDEPTH);
    last_acc = acc;
    chk("rd_accept", rd_accept, acc);
    @(posedge clk);
    case (ph)
      0: if (mq.size() > 0) begin cur = mq.pop_front(); ph = 1; end
      1: begin
        ev = 1'b1;
        if (cur >= 1 && cur <= 14) begin eo = bank[cur]; ee = 1'b0; end
        else begin eo = '0; ee = 1'b1; end
        ph = 2;
      end
      default: if (rdy) begin
        ev = 1'b0;
        if (mq.size() > 0) begin cur = mq.pop_front(); ph = 1; end
        else ph = 0;
      end
    endcase
    if (acc) mq.push_back(sel);
    #1;
    chk("bus_valid", bus_valid, ev);
    chk("bus_out", bus_out, eo);
    chk("bus_err", bus_err, ee);
    chk("q_count", q_count, mq.size());
    chk("busy", busy, (ph != 0) || (mq.size() > 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic       preq;
    logic [4:0] psel;
    for (int k = 1; k <= 14; k++) bank[k] = DATA_W'(16'h1000 + k);
    #3;
    do_reset();

    // Single read of slot 1, result two edges after acceptance.
    bank[1] = 16'h0005;
    cycle(1'b1, 5'd1, 1'b0);
    chk("t2_accept", last_acc, 1);
    cycle(1'b0, 5'd0, 1'b0);
    chk("t2_e1_valid", bus_valid, 0);
    cycle(1'b0, 5'd0, 1'b0);
    chk("t2_e2_out", bus_out, 16'h0005);
    chk("t2_e2_valid", bus_valid, 1);
    cycle(1'b0, 5'd0, 1'b1);

    // Invalid codes 0 and 20.
    cycle(1'b1, 5'd0, 1'b0);
    cycle(1'b0, 5'd0, 1'b0);
    cycle(1'b0, 5'd0, 1'b0);
    chk("t3_err0", bus_err, 1);
    cycle(1'b1, 5'd20, 1'b1);
    cycle(1'b0, 5'd0, 1'b0);
    cycle(1'b0, 5'd0, 1'b0);
    chk("t3_err20", bus_err, 1);
    chk("t3_out20", bus_out, 0);
    cycle(1'b0, 5'd0, 1'b1);

    // Result held while ready is low even though SUM changes.
    bank[8] = 16'hBEEF;
    cycle(1'b1, 5'd8, 1'b0);
    cycle(1'b0, 5'd0, 1'b0);
    cycle(1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bank[8] = DATA_W'($urandom);
      cycle(1'b0, 5'd0, 1'b0);
      chk("t4_hold", bus_out, 16'hBEEF);
    end
    cycle(1'b0, 5'd0, 1'b1);
    chk("t4_drop", bus_valid, 0);

    // Fill the queue while the consumer stalls, then drain M,P,R.
    bank[2] = 16'h2222; bank[3] = 16'h3333; bank[14] = 16'hEEEE;
    cycle(1'b1, 5'd7, 1'b0);
    cycle(1'b1, 5'd2, 1'b0);
    cycle(1'b1, 5'd3, 1'b0);
    cycle(1'b1, 5'd14, 1'b0);
    cycle(1'b1, 5'd5, 1'b0);
    chk("t5_full", q_count, QDEPTH);
    cycle(1'b1, 5'd6, 1'b0);
    chk("t5_refuse", last_acc, 0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 5'd0, 1'b1);

    // Reset while holding a result with requests still pending.
    cycle(1'b1, 5'd4, 1'b0);
    cycle(1'b1, 5'd9, 1'b0);
    cycle(1'b1, 5'd10, 1'b0);
    cycle(1'b0, 5'd0, 1'b0);
    chk("t6_inhold", bus_valid, 1);
    do_reset();
    cycle(1'b0, 5'd0, 1'b1);
    cycle(1'b0, 5'd0, 1'b0);

    // Randomized traffic; a refused request is held until accepted.
    preq = 1'b0; psel = '0;
    last_acc = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!preq || last_acc) begin
        preq = ($urandom_range(0, 99) < 60);
        psel = 5'($urandom_range(0, 31));
      end
      if ($urandom_range(0, 7) == 0) bank[$urandom_range(1, 14)] = DATA_W'($urandom);
      cycle(preq, psel, ($urandom_range(0, 99) < 55));
      if (i == 250) begin
        do_reset();
        preq = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
